// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: elastic valid/ready register pipeline with bubble collapsing and flush.
// Define PIPE_COUNT_EN to add the registered occupancy port count.
module pipe_reg_chain #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 3
) (
  input  logic             clock,
  input  logic             Resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_COUNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] count
`endif
);
  logic [DEPTH-1:0] v_q, v_d, r;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  // A stage can move when any stage from it to the output is empty or the output drains.
  for (genvar k = 0; k < DEPTH; k++) begin : g_rdy
    assign r[k] = out_ready | ~&(v_q | ~({DEPTH{1'b1}} << k));
  end
  assign in_ready  = r[0] & ~flush;
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (r[0]) begin
      v_d[0] = in_valid;
      d_d[0] = in_data;
    end
    for (int k = 1; k < DEPTH; k++) begin
      if (r[k]) begin
        v_d[k] = v_q[k-1];
        d_d[k] = d_q[k-1];
      end
    end
    if (flush) v_d = '0;
  end
  always_ff @(posedge clock or negedge Resetn) begin
    if (!Resetn) begin
      v_q <= '0;
      for (int k = 0; k < DEPTH; k++) d_q[k] <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end
`ifdef PIPE_COUNT_EN
  logic [$clog2(DEPTH+1)-1:0] count_q, count_d;
  logic in_x, out_x;
  assign in_x  = in_valid & in_ready;
  assign out_x = out_valid & out_ready;
  assign count = count_q;
  always_comb begin
    count_d = flush ? '0 :
              (in_x & ~out_x) ? count_q + 1'b1 :
              (out_x & ~in_x) ? count_q - 1'b1 : count_q;
  end
  always_ff @(posedge clock or negedge Resetn) begin
    if (!Resetn) count_q <= '0;
    else count_q <= count_d;
  end
`endif
endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb_pipe_reg_chain: directed self-checking bench for pipe_reg_chain with WIDTH=5, DEPTH=3.
module tb_pipe_reg_chain;
  logic       clock = 1'b0;
  logic       Resetn = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [4:0] out_data;
  int checks = 0;
  int errors = 0;
`ifdef PIPE_COUNT_EN
  logic [1:0] count;
`endif

  pipe_reg_chain #(.WIDTH(5), .DEPTH(3)) dut (
    .clock(clock), .Resetn(Resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef PIPE_COUNT_EN
    , .count(count)
`endif
  );

  always #5 clock = ~clock;

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    in_valid = 1'b1;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 5'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
`ifdef PIPE_COUNT_EN
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
`endif
    @(negedge clock);
    in_valid = 1'b0;
    Resetn = 1'b1;
    step;
  endtask

  task automatic test_stream;
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_valid = (i < 5);
      in_data = 5'(i + 1);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d] got %b want 1", i, in_ready); end
      step;
      checks++; if (out_valid !== (i >= 2 && i <= 6)) begin errors++; $display("FAIL stream_out_valid[%0d] got %b want %b", i, out_valid, (i >= 2 && i <= 6)); end
      if (i >= 2 && i <= 6) begin
        checks++; if (out_data !== 5'(i - 1)) begin errors++; $display("FAIL stream_out_data[%0d] got %h want %h", i, out_data, 5'(i - 1)); end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_stall;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data = 5'h0A + 5'(i);
      #1;
      checks++; if (in_ready !== (i < 3)) begin errors++; $display("FAIL stall_in_ready[%0d] got %b want %b", i, in_ready, (i < 3)); end
      if (i < 3) step;
    end
`ifdef PIPE_COUNT_EN
    checks++; if (count !== 2'd3) begin errors++; $display("FAIL stall_count got %0d want 3", count); end
`endif
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid[%0d] got %b want 1", j, out_valid); end
      checks++; if (out_data !== 5'h0A + 5'(j)) begin errors++; $display("FAIL stall_out_data[%0d] got %h want %h", j, out_data, 5'h0A + 5'(j)); end
      step;
      in_valid = 1'b0;
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drained got %b want 0", out_valid); end
  endtask

  task automatic test_bubble;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 5'h11; step;
    in_valid = 1'b0; step;
    in_valid = 1'b1; in_data = 5'h12; step;
    in_data = 5'h13;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bubble_in_ready got %b want 1", in_ready); end
    step;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bubble_full got %b want 0", in_ready); end
    checks++; if (out_data !== 5'h11) begin errors++; $display("FAIL bubble_out_data got %h want 11", out_data); end
`ifdef PIPE_COUNT_EN
    checks++; if (count !== 2'd3) begin errors++; $display("FAIL bubble_count got %0d want 3", count); end
`endif
  endtask

  task automatic test_passthrough;
    in_valid = 1'b1; in_data = 5'h14; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL pass_in_ready got %b want 1", in_ready); end
    step;
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks++; if (out_data !== 5'h12) begin errors++; $display("FAIL pass_out_data got %h want 12", out_data); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL pass_full got %b want 0", in_ready); end
`ifdef PIPE_COUNT_EN
    checks++; if (count !== 2'd3) begin errors++; $display("FAIL pass_count got %0d want 3", count); end
`endif
    out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      #1;
      checks++; if (out_valid !== 1'b1 || out_data !== 5'h12 + 5'(j)) begin errors++; $display("FAIL pass_drain[%0d] got %b/%h want 1/%h", j, out_valid, out_data, 5'h12 + 5'(j)); end
      step;
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pass_empty got %b want 0", out_valid); end
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 5'h15; step;
    in_data = 5'h16; step;
    in_data = 5'h17; flush = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
    step;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready_after got %b want 1", in_ready); end
`ifdef PIPE_COUNT_EN
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL flush_count got %0d want 0", count); end
`endif
    for (int j = 0; j < 4; j++) begin
      step;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost[%0d] got %b want 0", j, out_valid); end
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 5'h1A + 5'(i); step;
    end
    in_valid = 1'b0;
    #2 Resetn = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 5'h00) begin errors++; $display("FAIL midreset_out got %b/%h want 0/00", out_valid, out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready got %b want 1", in_ready); end
`ifdef PIPE_COUNT_EN
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL midreset_count got %0d want 0", count); end
`endif
    @(negedge clock);
    Resetn = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 5'h1E;
    step;
    in_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      checks++; if (out_valid !== (j == 2)) begin errors++; $display("FAIL postreset_valid[%0d] got %b want %b", j, out_valid, (j == 2)); end
      if (j < 2) step;
    end
    checks++; if (out_data !== 5'h1E) begin errors++; $display("FAIL postreset_data got %h want 1E", out_data); end
    step;
  endtask

  initial begin
    test_reset;
    test_stream;
    test_stall;
    test_bubble;
    test_passthrough;
    test_flush;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
